// File: rtl/audio_tdm_tx.sv
// audio_tdm_tx -- TDM / I2S serial audio transmitter.
//
// Takes one whole frame (CHANNELS samples) at a time through a single-entry
// holding buffer and serialises it MSB first, slot 0 first, on sdata. The
// bit clock sclk is derived from clk by a half-period prescaler. lrclk is
// low for the first half of the frame and high for the second half.
// mode = 1 gives left-justified timing; mode = 0 gives I2S timing, where
// data lags lrclk by one sclk period.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   prescaler  in   sclk half-period in clk cycles (0 behaves as 1)
//   mode       in   0 = I2S, 1 = left-justified (sampled at frame load)
//   s_valid    in   frame offered
//   s_data     in   CHANNELS*SAMPLE_W frame samples, channel 0 in the LSBs
//   s_ready    out  holding buffer empty
//   sclk       out  serial bit clock
//   lrclk      out  frame / word select
//   sdata      out  serial data, MSB first
//   underrun   out  one-clk pulse when a frame load finds no data
module audio_tdm_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 16,
    parameter int CHANNELS   = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [PRESCALE_W-1:0]          prescaler,
    input  logic                           mode,
    input  logic                           s_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0]   s_data,
    output logic                           s_ready,
    output logic                           sclk,
    output logic                           lrclk,
    output logic                           sdata,
    output logic                           underrun
);

    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int PW    = $clog2(FRAME);

    // Lays the samples out in transmit order: the MSB of the returned vector
    // is the first serial bit. Each slot holds its sample MSB first and is
    // zero padded after the sample LSB.
    function automatic logic [FRAME-1:0] build_frame(
        input logic [CHANNELS*SAMPLE_W-1:0] d
    );
        logic [FRAME-1:0] f;
        f = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < SAMPLE_W; b++) begin
                f[FRAME-1 - c*SLOT_W - b] = d[c*SAMPLE_W + SAMPLE_W-1 - b];
            end
        end
        return f;
    endfunction

    logic [PRESCALE_W-1:0]         hcnt;
    logic [PRESCALE_W-1:0]         half_max;
    logic                          tick;
    logic                          fall;
    logic                          load;
    logic [PW-1:0]                 pos;
    logic [PW-1:0]                 pos_next;
    logic [FRAME-1:0]              shreg;
    logic [FRAME-1:0]              load_frame;
    logic                          last_bit;
    logic                          hold_full;
    logic [CHANNELS*SAMPLE_W-1:0]  hold_data;

    // The limit is compared with >= so that lowering the prescaler while the
    // counter is already past the new limit ends the current half-period on
    // the next clk instead of waiting for the counter to wrap.
    assign half_max   = (prescaler == '0) ? '0 : prescaler - PRESCALE_W'(1);
    assign tick       = (hcnt >= half_max);
    assign fall       = tick && sclk;
    assign load       = fall && (pos == PW'(FRAME-1));
    assign pos_next   = (pos == PW'(FRAME-1)) ? '0 : pos + PW'(1);
    assign load_frame = hold_full ? build_frame(hold_data) : '0;
    assign s_ready    = !hold_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt      <= '0;
            sclk      <= 1'b0;
            pos       <= PW'(FRAME-1);
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            shreg     <= '0;
            last_bit  <= 1'b0;
            hold_full <= 1'b0;
            hold_data <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (tick) begin
                hcnt <= '0;
                sclk <= ~sclk;
            end else begin
                hcnt <= hcnt + PRESCALE_W'(1);
            end

            // Capture is independent of frame load: data accepted in the
            // load cycle lands in the buffer and waits for the next frame.
            if (s_valid && !hold_full) begin
                hold_data <= s_data;
                hold_full <= 1'b1;
            end

            if (fall) begin
                pos   <= pos_next;
                lrclk <= (pos_next >= PW'(FRAME/2));
                if (load) begin
                    // last_bit keeps the final serial bit of the new frame so
                    // that an I2S frame can emit it one position late, no
                    // matter which mode the previous frame used.
                    last_bit <= load_frame[0];
                    if (mode) begin
                        sdata <= load_frame[FRAME-1];
                        shreg <= load_frame << 1;
                    end else begin
                        sdata <= last_bit;
                        shreg <= load_frame;
                    end
                    if (hold_full) begin
                        hold_full <= 1'b0;
                    end else begin
                        underrun <= 1'b1;
                    end
                end else begin
                    sdata <= shreg[FRAME-1];
                    shreg <= shreg << 1;
                end
            end
        end
    end

endmodule
